// File: rtl/apb_master_if.sv
// apb_master_if: command/response port plus APB segment bundled for apb_master
interface apb_master_if #(parameter int ADDR_W = 8, parameter int DATA_W = 8);
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr, paddr;
  logic [DATA_W-1:0] cmd_wdata, rsp_rdata, pwdata, prdata;
  logic              rsp_valid, rsp_write, psel, penable, pwrite, pready;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, psel, penable, pwrite, paddr, pwdata
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master.sv
// apb_master: single-outstanding valid/ready to APB requester, all outputs registered.
// Define APB_PREADY_EN to honour pready wait states; otherwise ACCESS lasts one cycle.
module apb_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input logic          clk,
  input logic          rst,
  apb_master_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;
  state_t            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d, psel_q, psel_d, penable_q, penable_d;
  logic              pwrite_q, pwrite_d, rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
  logic              hs, done;
`ifdef APB_PREADY_EN
  assign done = bus.pready;
`else
  logic unused_pready;
  assign unused_pready = bus.pready;
  assign done = 1'b1;
`endif
  // cmd_ready_q is only ever high in IDLE, so it alone qualifies the handshake
  assign hs = bus.cmd_valid && cmd_ready_q;
  always_comb begin
    state_d     = (state_q == IDLE)   ? (hs ? SETUP : IDLE) :
                  (state_q == SETUP)  ? ACCESS :
                  (state_q == ACCESS && !done) ? ACCESS : IDLE;
    cmd_ready_d = state_d == IDLE;
    psel_d      = state_d != IDLE;
    penable_d   = state_d == ACCESS;
    pwrite_d    = hs ? bus.cmd_write : pwrite_q;
    paddr_d     = hs ? bus.cmd_addr  : paddr_q;
    pwdata_d    = hs ? bus.cmd_wdata : pwdata_q;
    rsp_valid_d = state_q == ACCESS && done;
    rsp_write_d = rsp_valid_d ? pwrite_q : rsp_write_q;
    rsp_rdata_d = rsp_valid_d ? (pwrite_q ? '0 : bus.prdata) : rsp_rdata_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed transfers; driver pushes expected responses, monitor pops on rsp_valid
module tb_apb_master;
`ifdef APB_PREADY_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  typedef struct {logic w; logic [7:0] d; int cyc;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  int   checks = 0, errors = 0, cyc = 0;
  exp_t q[$];
  exp_t e;
  logic prev = 1'b0;
  apb_master_if #(.ADDR_W(8), .DATA_W(8)) bus ();
  apb_master #(.ADDR_W(8), .DATA_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at cycle %0d", n, a, x, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected got rsp_valid=1 exp no response at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        chk("rsp_write", {31'd0, bus.rsp_write}, {31'd0, e.w});
        chk("rsp_rdata", {24'd0, bus.rsp_rdata}, {24'd0, e.d});
        chk("rsp_cycle", cyc, e.cyc);
      end
      chk("rsp_pulse_width", {31'd0, prev}, 32'd0);
    end
    prev = bus.rsp_valid;
  end
  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  // pw: cycles pready is held low in ACCESS; hv: keep cmd_valid asserted afterwards
  task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] rd, input int pw, input bit hv);
    int n = 0;
    int ew = EN ? pw : 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.prdata    = rd;
    bus.pready    = (pw == 0);
    while (!bus.cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      chk("cmd_ready_timeout", 32'd0, 32'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    q.push_back('{w, w ? 8'h00 : rd, cyc + 2 + ew});
    if (!hv) bus.cmd_valid = 1'b0;
    chk("setup_psel", {31'd0, bus.psel}, 32'd1);
    chk("setup_penable", {31'd0, bus.penable}, 32'd0);
    chk("setup_pwrite", {31'd0, bus.pwrite}, {31'd0, w});
    chk("setup_paddr", {24'd0, bus.paddr}, {24'd0, a});
    chk("setup_pwdata", {24'd0, bus.pwdata}, {24'd0, d});
    chk("setup_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    @(posedge clk); #1;
    chk("access_psel", {31'd0, bus.psel}, 32'd1);
    chk("access_penable", {31'd0, bus.penable}, 32'd1);
    chk("access_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    for (int i = 0; i < ew; i++) begin
      @(posedge clk); #1;
      chk("wait_penable", {31'd0, bus.penable}, 32'd1);
      chk("wait_paddr", {24'd0, bus.paddr}, {24'd0, a});
      chk("wait_pwdata", {24'd0, bus.pwdata}, {24'd0, d});
      if (i == ew - 1) bus.pready = 1'b1;
    end
    @(posedge clk); #1;
    chk("done_psel", {31'd0, bus.psel}, 32'd0);
    chk("done_penable", {31'd0, bus.penable}, 32'd0);
    chk("done_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    bus.pready = 1'b1;
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.prdata    = '0;
    bus.pready    = 1'b1;
    @(posedge clk); #1;
    chk("rst_psel", {31'd0, bus.psel}, 32'd0);
    chk("rst_penable", {31'd0, bus.penable}, 32'd0);
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_paddr", {24'd0, bus.paddr}, 32'd0);
    chk("rst_pwdata", {24'd0, bus.pwdata}, 32'd0);
    chk("rst_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
    @(negedge clk) rst = 1'b0;
    #1 chk("pre_edge_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    @(posedge clk); #1;
    chk("post_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    xfer(1'b1, 8'h10, 8'hA5, 8'h5F, 0, 1'b0);
    xfer(1'b0, 8'h10, 8'h00, 8'h3C, 0, 1'b0);
    xfer(1'b1, 8'h00, 8'h11, 8'h77, 0, 1'b1);
    xfer(1'b1, 8'h01, 8'h22, 8'h00, 0, 1'b1);
    xfer(1'b1, 8'hFF, 8'h33, 8'h00, 0, 1'b0);
    xfer(1'b1, 8'h42, 8'h5A, 8'h00, 2, 1'b0);
    xfer(1'b0, 8'h43, 8'h00, 8'hC3, 1, 1'b0);
    chk("rdata_hold", {24'd0, bus.rsp_rdata}, 32'hC3);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h20;
    bus.prdata    = 8'hEE;
    bus.pready    = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_access_penable", {31'd0, bus.penable}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_psel", {31'd0, bus.psel}, 32'd0);
    chk("abort_penable", {31'd0, bus.penable}, 32'd0);
    chk("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    bus.pready = 1'b1;
    #1 chk("abort_cmd_ready_low", {31'd0, bus.cmd_ready}, 32'd0);
    @(posedge clk); #1;
    chk("abort_cmd_ready_high", {31'd0, bus.cmd_ready}, 32'd1);
    xfer(1'b0, 8'h55, 8'h00, 8'h81, 0, 1'b0);
    repeat (5) @(posedge clk);
    #1 chk("scoreboard_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB requester that converts a simple valid/ready command port into APB SETUP/ACCESS transfers toward an 8-bit APB completer such as the team's APB memory slave. Captures read data on completion and returns it on a one-cycle response strobe. Sits between an internal controller and the APB segment; one clock domain.

## Interface
- ADDR_W, default 8: width of cmd_addr / paddr.
- DATA_W, default 8: width of cmd_wdata / pwdata / prdata / rsp_rdata.

- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted on a clk edge where cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_write  out  1  direction of the completed transfer.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB completer ready; used only with APB_PREADY_EN.

## Operation
- States: IDLE, SETUP, ACCESS (2-bit encoded register). All outputs registered.
- IDLE: cmd_ready=1, psel=0, penable=0. On handshake: latch cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata, go SETUP. No handshake: stay IDLE.
- SETUP: psel=1, penable=0, cmd_ready=0. Unconditionally go ACCESS next edge.
- ACCESS: psel=1, penable=1, cmd_ready=0. Completion condition: pready=1 (macro defined) or always true (macro undefined). On completion: rsp_valid=1 next cycle, rsp_write=pwrite, rsp_rdata=prdata if read else 0; go IDLE. Not complete: hold ACCESS, all APB outputs stable.
- pwrite/paddr/pwdata constant from SETUP through last ACCESS cycle; retain last value in IDLE.
- rsp_rdata holds last captured value until next completion; rsp_valid is high exactly one cycle per transfer.
- Exactly one transfer outstanding; no command accepted until back in IDLE.
- Illegal state encoding -> IDLE.

## Timing
- Reset (async, immediate): state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, cmd_ready=0 while rst high, 1 from first clk edge after rst low.
- Handshake at edge E0 -> SETUP during cycle after E0 -> ACCESS after E1 -> zero-wait completion at E2, rsp_valid high after E2, cmd_ready high after E2 (IDLE).
- Minimum 3 cycles per transfer (IDLE, SETUP, ACCESS); each wait state adds 1.
- prdata sampled on the same edge that ends ACCESS.
- rst asserted mid-SETUP/ACCESS: transfer abandoned, psel/penable drop immediately, no rsp_valid.
- cmd_valid with cmd_ready=0: ignored; requester must hold until accepted.

## Configuration
- APB_PREADY_EN defined: ACCESS extends while pready=0 (APB3 wait states), no timeout.
- Undefined: pready ignored; ACCESS lasts exactly one cycle (matches completers without pready).

## Test plan
- Reset: rst pulse mid-ACCESS -> psel=penable=0 asynchronously, no rsp_valid, cmd_ready=1 one edge after release.
- Write addr 0x10 data 0xA5 -> SETUP with psel=1/penable=0/paddr=0x10/pwdata=0xA5/pwrite=1, ACCESS next cycle, rsp_valid=1 rsp_write=1 rsp_rdata=0.
- Read addr 0x10 with prdata=0x3C in ACCESS -> rsp_valid=1, rsp_write=0, rsp_rdata=0x3C; three cycles handshake to rsp.
- Back-to-back: cmd_valid held with writes to 0x00, 0x01, 0xFF -> each accepted only in IDLE, three SETUP/ACCESS pairs, three rsp_valid pulses.
- APB_PREADY_EN: pready=0 for 2 ACCESS cycles -> paddr/pwdata stable, penable=1 for 3 cycles, single rsp_valid after pready=1.
- Macro undefined: pready tied 0 -> transfer completes after one ACCESS cycle anyway.
